// File: rtl/cp0_intctl.sv
// cp0_intctl: coprocessor-0 interrupt controller.
// Holds Status/Cause/EPC, samples the hardware interrupt lines into Cause.IP,
// and raises TakenInterrupt when an enabled, unmasked interrupt is pending
// and the CPU is not already in the handler (EXL) or stalled.
module cp0_intctl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h80000180,
  parameter int          NUM_HW_IRQ   = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_HW_IRQ-1:0] irq,
  input  logic [4:0]            regnum,
  input  logic [31:0]           wr_data,
  input  logic                  MTC0,
  input  logic                  ERET,
  input  logic                  stall,
  input  logic [31:0]           next_pc,
  output logic [31:0]           rd_data,
  output logic [31:0]           EPC,
  output logic                  TakenInterrupt,
  output logic [31:0]           InterruptHandlerAddr
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  // EXL is the mode of the controller: NORMAL runs code, HANDLER blocks nesting.
  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_t;

  state_t                state, state_nx;
  logic                  ie;
  logic [7:0]            im;
  logic [NUM_HW_IRQ-1:0] ip_hw;
  logic [1:0]            ip_sw;
  logic [31:0]           epc_q;
  logic                  exl;
  logic                  pending;
  logic                  wr_status, wr_cause, wr_epc;
  logic [31:0]           status_val, cause_val;

  assign exl        = (state == HANDLER);
  assign status_val = {16'h0, im, 6'h0, exl, ie};
  assign cause_val  = {16'h0, ip_hw, ip_sw, 8'h0};
  assign pending    = |(cause_val[15:8] & im);

  // The reset term keeps the redirect quiet while the controller is held in reset.
  assign TakenInterrupt       = pending & ie & ~exl & ~stall & reset;
  assign EPC                  = epc_q;
  assign InterruptHandlerAddr = HANDLER_ADDR;

  // A taken interrupt squashes the MTC0 in the same cycle, so writes are gated by it.
  assign wr_status = MTC0 & ~TakenInterrupt & (regnum == REG_STATUS);
  assign wr_cause  = MTC0 & ~TakenInterrupt & (regnum == REG_CAUSE);
  assign wr_epc    = MTC0 & ~TakenInterrupt & (regnum == REG_EPC);

  // Mode register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= NORMAL;
    else        state <= state_nx;
  end

  // Next mode: interrupt entry wins; otherwise an MTC0 to Status sets EXL and ERET then clears it.
  always_comb begin
    state_nx = state;
    if (TakenInterrupt) begin
      state_nx = HANDLER;
    end else begin
      if (wr_status) state_nx = wr_data[1] ? HANDLER : NORMAL;
      if (ERET)      state_nx = NORMAL;
    end
  end

  // Status/Cause/EPC contents; IP hardware bits track the lines one cycle late.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ie    <= 1'b0;
      im    <= 8'h0;
      ip_hw <= '0;
      ip_sw <= 2'b0;
      epc_q <= 32'h0;
    end else begin
      ip_hw <= irq;
      if (wr_status) begin
        ie <= wr_data[0];
        im <= wr_data[15:8];
      end
      if (wr_cause) ip_sw <= wr_data[9:8];
      if (TakenInterrupt) epc_q <= next_pc;
      else if (wr_epc)    epc_q <= wr_data;
    end
  end

  // MFC0 read mux; unimplemented registers read as zero.
  always_comb begin
    rd_data = 32'h0;
    case (regnum)
      REG_STATUS: rd_data = status_val;
      REG_CAUSE:  rd_data = cause_val;
      REG_EPC:    rd_data = epc_q;
      default:    rd_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intctl.sv
// Scoreboard bench for cp0_intctl: stimulus pushes hand-computed expectations,
// a monitor pops one per falling edge and compares rd_data, TakenInterrupt,
// EPC and the handler address.
module tb_cp0_intctl;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  irq;
  logic [4:0]  regnum;
  logic [31:0] wr_data;
  logic        MTC0, ERET, stall;
  logic [31:0] next_pc;
  logic [31:0] rd_data, EPC, InterruptHandlerAddr;
  logic        TakenInterrupt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        tk;
    logic [31:0] epc;
  } exp_t;

  exp_t q[$];

  cp0_intctl #(.HANDLER_ADDR(32'h80000180), .NUM_HW_IRQ(6)) dut (
    .clock(clock), .reset(reset), .irq(irq), .regnum(regnum),
    .wr_data(wr_data), .MTC0(MTC0), .ERET(ERET), .stall(stall),
    .next_pc(next_pc), .rd_data(rd_data), .EPC(EPC),
    .TakenInterrupt(TakenInterrupt), .InterruptHandlerAddr(InterruptHandlerAddr)
  );

  always #5 clock = ~clock;

  // Monitor: at each falling edge compare the oldest expectation with the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (rd_data !== e.rd) begin
          errors++;
          $display("FAIL %s rd_data: got %h expected %h", e.name, rd_data, e.rd);
        end
        checks++;
        if (TakenInterrupt !== e.tk) begin
          errors++;
          $display("FAIL %s TakenInterrupt: got %b expected %b", e.name, TakenInterrupt, e.tk);
        end
        checks++;
        if (EPC !== e.epc) begin
          errors++;
          $display("FAIL %s EPC: got %h expected %h", e.name, EPC, e.epc);
        end
        checks++;
        if (InterruptHandlerAddr !== 32'h80000180) begin
          errors++;
          $display("FAIL %s handler_addr: got %h expected 80000180", e.name, InterruptHandlerAddr);
        end
      end
    end
  end

  // Watchdog so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] rn, input logic [31:0] d);
    regnum  = rn;
    wr_data = d;
    MTC0    = 1'b1;
    step();
    MTC0    = 1'b0;
  endtask

  task automatic eret();
    ERET = 1'b1;
    step();
    ERET = 1'b0;
  endtask

  // Queue an expectation for the next falling edge, then move just past it.
  task automatic chk(input string name, input logic [4:0] rn, input logic [31:0] rd,
                     input logic tk, input logic [31:0] epc);
    exp_t e;
    regnum = rn;
    e.name = name;
    e.rd   = rd;
    e.tk   = tk;
    e.epc  = epc;
    q.push_back(e);
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; irq = 6'h0; regnum = 5'd0; wr_data = 32'h0;
    MTC0 = 1'b0; ERET = 1'b0; stall = 1'b0; next_pc = 32'h0;

    chk("reset_status", 5'd12, 32'h0, 1'b0, 32'h0);
    step();
    reset = 1'b1;
    step();

    // Timer interrupt taken
    mtc0(5'd12, 32'h00008001);
    mtc0(5'd13, 32'h00000000);
    chk("status_wr", 5'd12, 32'h00008001, 1'b0, 32'h0);
    irq = 6'b100000;
    next_pc = 32'h00400010;
    step();
    chk("timer_cause", 5'd13, 32'h00008000, 1'b1, 32'h0);
    chk("timer_entry", 5'd12, 32'h00008003, 1'b0, 32'h00400010);

    // No nesting while EXL=1, then ERET re-enables
    irq = 6'b100001;
    mtc0(5'd12, 32'h0000ff03);
    chk("nest_status", 5'd12, 32'h0000ff03, 1'b0, 32'h00400010);
    chk("nest_cause", 5'd13, 32'h00008400, 1'b0, 32'h00400010);
    eret();
    chk("eret_status", 5'd12, 32'h0000ff01, 1'b1, 32'h00400010);
    next_pc = 32'h00400020;
    chk("reenter", 5'd12, 32'h0000ff03, 1'b0, 32'h00400020);

    // Masking and stall
    irq = 6'h0;
    eret();
    irq = 6'b100000;
    mtc0(5'd12, 32'h00000001);
    chk("mask_im0", 5'd13, 32'h00008000, 1'b0, 32'h00400020);
    chk("mask_status", 5'd12, 32'h00000001, 1'b0, 32'h00400020);
    stall = 1'b1;
    mtc0(5'd12, 32'h00008001);
    chk("stall_hold", 5'd12, 32'h00008001, 1'b0, 32'h00400020);
    step();
    stall = 1'b0;
    next_pc = 32'h00400030;
    chk("stall_drop", 5'd12, 32'h00008001, 1'b1, 32'h00400020);
    chk("stall_take", 5'd12, 32'h00008003, 1'b0, 32'h00400030);

    // Software interrupt
    irq = 6'h0;
    eret();
    mtc0(5'd12, 32'h00000101);
    mtc0(5'd13, 32'h00000100);
    next_pc = 32'h00400040;
    chk("sw_cause", 5'd13, 32'h00000100, 1'b1, 32'h00400030);
    chk("sw_take", 5'd12, 32'h00000103, 1'b0, 32'h00400040);
    irq = 6'b000001;
    mtc0(5'd13, 32'hffffffff);
    chk("cause_wmask", 5'd13, 32'h00000700, 1'b0, 32'h00400040);

    // Collision: interrupt entry beats MTC0 to EPC
    eret();
    next_pc = 32'h00400044;
    mtc0(5'd14, 32'h12345678);
    chk("coll_epc", 5'd14, 32'h00400044, 1'b0, 32'h00400044);

    // MTC0 Status together with ERET: EXL ends cleared
    stall = 1'b1;
    ERET = 1'b1;
    mtc0(5'd12, 32'h00000003);
    ERET = 1'b0;
    chk("eret_mtc0", 5'd12, 32'h00000001, 1'b0, 32'h00400044);
    // MTC0 EPC together with ERET: write applied; ERET in NORMAL is a no-op
    ERET = 1'b1;
    mtc0(5'd14, 32'h12345678);
    ERET = 1'b0;
    chk("eret_epc", 5'd14, 32'h12345678, 1'b0, 32'h12345678);
    chk("eret_noop", 5'd12, 32'h00000001, 1'b0, 32'h12345678);
    stall = 1'b0;
    chk("mfc0_r5", 5'd5, 32'h0, 1'b0, 32'h12345678);

    // Asynchronous reset mid-operation
    mtc0(5'd14, 32'h00400020);
    mtc0(5'd12, 32'h0000ff03);
    chk("pre_reset", 5'd12, 32'h0000ff03, 1'b0, 32'h00400020);
    reset = 1'b0;
    chk("rst_status", 5'd12, 32'h0, 1'b0, 32'h0);
    chk("rst_epc", 5'd14, 32'h0, 1'b0, 32'h0);
    irq = 6'h0;
    reset = 1'b1;
    chk("post_cause", 5'd13, 32'h0, 1'b0, 32'h0);
    chk("post_status", 5'd12, 32'h0, 1'b0, 32'h0);
    chk("post_epc", 5'd14, 32'h0, 1'b0, 32'h0);

    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_intctl.md
Name: cp0_intctl

Overview:
Coprocessor-0 interrupt controller sitting directly downstream of the memory-mapped timer. It consumes TimerInterrupt and the other external interrupt lines, holds the Status, Cause and EPC registers, and decides when the CPU takes an interrupt. On a taken interrupt it tells the datapath to redirect fetch to the handler. ERET returns control by restoring normal mode.

Parameters:
HANDLER_ADDR, 32'h80000180, PC that fetch is redirected to when an interrupt is taken
NUM_HW_IRQ, 6, number of hardware interrupt lines, mapped to Cause/Status bits 15:10

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 forces all state to its reset value
irq  input  NUM_HW_IRQ  level-sensitive hardware interrupt lines; TimerInterrupt drives irq[5]
regnum  input  5  coprocessor register number for MTC0/MFC0
wr_data  input  32  MTC0 write data
MTC0  input  1  write strobe for regnum
ERET  input  1  return-from-exception strobe
stall  input  1  pipeline stalled; no interrupt may be taken
next_pc  input  32  PC of the instruction to resume at after the interrupt
rd_data  output  32  MFC0 read data
EPC  output  32  current EPC register value
TakenInterrupt  output  1  redirect fetch to HANDLER_ADDR this cycle
InterruptHandlerAddr  output  32  constant HANDLER_ADDR

Behaviour:
- Status (reg 12): bit 0 IE, bit 1 EXL, bits 15:8 IM, all other bits read 0. Cause (reg 13): bits 15:8 IP, bits 6:2 ExcCode (always 0 = interrupt), others read 0. EPC is reg 14.
- Reset (reset=0, asynchronous): Status=0, Cause=0, EPC=0, so TakenInterrupt=0. State holds while reset=0; normal operation resumes on the first rising edge after release.
- IP sampling: each rising edge, Cause[15:10] <= irq. Latency from irq to IP is one cycle. IP is level-based, not sticky; the source (e.g. timer acknowledge) clears it.
- Cause[9:8] are software interrupt bits, writable only via MTC0 to reg 13. Every other Cause bit ignores writes.
- pending = |(Cause[15:8] & Status[15:8]).
- TakenInterrupt = pending & IE & ~EXL & ~stall & reset. This is combinational from registered state.
- Two-state machine keyed on EXL:
  - NORMAL (EXL=0) -> HANDLER (EXL=1) on a rising edge with TakenInterrupt=1. In the same edge, EPC <= next_pc.
  - HANDLER -> NORMAL on a rising edge with ERET=1.
  - ERET in NORMAL is a no-op.
  - Interrupts cannot nest: TakenInterrupt stays 0 while EXL=1.
- MTC0 writes:
  - reg 12 writes bits 15:8 and 1:0.
  - reg 13 writes bits 9:8.
  - reg 14 writes all 32 bits.
  - Writes to other regnums are ignored.
- Priority in one cycle:
  - TakenInterrupt beats MTC0: the write is dropped because that instruction is squashed. EPC and EXL take the interrupt values.
  - MTC0 to Status with ERET: ERET clears EXL after the MTC0 value is applied, so final EXL=0.
  - MTC0 to reg 14 with ERET: the EPC write is applied.
- MFC0: rd_data = selected register (12/13/14), combinational from current register state. Any other regnum returns 32'h0.
- IE/IM changes by MTC0 affect TakenInterrupt starting the cycle after the write edge.
- EPC output always reflects the EPC register. The datapath uses it as the ERET target.

Test Plan:
- Reset sequencing: reset=0 mid-operation with EXL=1 and EPC=32'h00400020 -> immediately Status=0, EPC=0, TakenInterrupt=0. After release, all MFC0 reads return 0.
- Timer interrupt taken: write Status=32'h00008001 and Cause=0; raise irq[5]; set next_pc=32'h00400010.
  - One cycle later: Cause=32'h00008000 and TakenInterrupt=1.
  - Next edge: EPC=32'h00400010, Status=32'h00008003, TakenInterrupt=0.
- Masking and stall:
  - IM=0 with irq[5]=1 -> TakenInterrupt stays 0.
  - IE=1, IM=8'h80, stall=1 -> TakenInterrupt=0. Dropping stall gives TakenInterrupt=1 in the same cycle.
- Nesting and ERET:
  - While EXL=1, raise irq[0] with IM=8'hff -> TakenInterrupt=0.
  - ERET -> EXL=0, and TakenInterrupt=1 the next cycle if irq is still high.
- Software interrupt: MTC0 reg 13 wr_data=32'h00000100 with Status=32'h00000101 -> Cause reads 32'h00000100 and TakenInterrupt=1 the next cycle. Writing 32'hffffffff to Cause reads back only bits 9:8 set plus the sampled IP.
- Collisions:
  - MTC0 reg 14 = 32'h12345678 in the same cycle as TakenInterrupt=1 with next_pc=32'h00400044 -> EPC=32'h00400044.
  - MFC0 reg 5 -> rd_data=0.
